stream_checksum: RTL and testbench

- Sequential, streaming successor to the combinational N-word checksum. It accumulates a 1's-complement sum over a packet of WIDTH-bit words arriving on a valid/ready stream.
- Per packet it emits either the checksum to insert (generate mode) or a pass/fail flag (verify mode), plus a word count and an overlength error.
- Sits between the packet framer and the transmit/receive datapath. Packet length is not fixed at elaboration time.

---
 rtl/checksum_pkg.sv | 28 ++
 rtl/stream_checksum_adder.sv | 14 +
 rtl/stream_checksum.sv | 157 +++++++++++++++
 tb/tb_stream_checksum.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/checksum_pkg.sv
// Shared types and arithmetic for the streaming 1's-complement checksum.
package checksum_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_VER = 1'b1;

    // Folded 1's-complement add on the low `width` bits (width <= 64).
    function automatic logic [63:0] ones_add(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input int          width);
        logic [64:0] t;
        logic [63:0] mask;
        if (width >= 64) begin
            mask = {64{1'b1}};
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        t = {1'b0, a & mask} + {1'b0, b & mask};
        return (t[63:0] & mask) + {63'd0, t[width]};
    endfunction

endpackage

// File: rtl/stream_checksum_adder.sv
// Combinational WIDTH-bit 1's-complement adder with end-around carry.
module ones_comp_adder
    import checksum_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = WIDTH'(ones_add(64'(i_a), 64'(i_b), WIDTH));

endmodule

// File: rtl/stream_checksum.sv
// Streaming 1's-complement checksum: accumulates a packet of words and
// reports the checksum (generate) or a pass flag (verify) once per packet.
module stream_checksum
    import checksum_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter int              MAX_WORDS = 16,
    parameter logic [WIDTH-1:0] SEED     = {WIDTH{1'b0}},
    localparam int             CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             abort,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_checksum,
    output logic             m_ok,
    output logic             m_err,
    output logic [CW-1:0]    m_count
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic             r_err;
    logic             r_mode;
    logic             r_s_ready;
    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_checksum;
    logic             r_m_ok;
    logic             r_m_err;
    logic [CW-1:0]    r_m_count;

    logic             w_accept;
    logic             w_load;
    logic             w_clear;
    logic             w_overflow;
    logic             w_mode_eff;
    logic             w_err_next;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_sum;

    // The first word of a packet always starts from SEED, whatever acc holds.
    assign w_base       = (r_state == IDLE) ? SEED : r_acc;
    assign w_accept     = s_valid & r_s_ready & ~abort;
    assign w_load       = w_accept & s_last;
    assign w_overflow   = w_accept & (r_count == MAX_CNT);
    assign w_err_next   = r_err | w_overflow;
    assign w_count_next = (r_count == MAX_CNT) ? r_count : (r_count + CW'(1));
    assign w_mode_eff   = (r_state == IDLE) ? mode : r_mode;

    ones_comp_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a   (w_base),
        .i_b   (s_data),
        .o_sum (w_sum)
    );

    // Next-state decode; w_clear flags every return to a fresh packet.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            IDLE, ACCUM: begin
                if (abort) begin
                    w_state_next = IDLE;
                    w_clear      = 1'b1;
                end else if (w_accept && s_last) begin
                    w_state_next = RESULT;
                end else if (w_accept) begin
                    w_state_next = ACCUM;
                end else begin
                    w_state_next = r_state;
                end
            end
            RESULT: begin
                if (m_ready) begin
                    w_state_next = IDLE;
                    w_clear      = 1'b1;
                end else begin
                    w_state_next = RESULT;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_clear      = 1'b1;
            end
        endcase
    end

    // State and handshake flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_s_ready <= (w_state_next != RESULT);
            r_m_valid <= (w_state_next == RESULT);
        end
    end

    // Accumulator, word counter, overflow flag and sampled mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= SEED;
            r_count <= {CW{1'b0}};
            r_err   <= 1'b0;
            r_mode  <= 1'b0;
        end else if (w_clear) begin
            r_acc   <= SEED;
            r_count <= {CW{1'b0}};
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= w_count_next;
            r_err   <= w_err_next;
            if (r_state == IDLE) begin
                r_mode <= mode;
            end
        end
    end

    // Result registers, loaded once as the packet's last word is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_checksum <= {WIDTH{1'b0}};
            r_m_ok       <= 1'b0;
            r_m_err      <= 1'b0;
            r_m_count    <= {CW{1'b0}};
        end else if (w_load) begin
            r_m_checksum <= ~w_sum;
            r_m_ok       <= (w_mode_eff == MODE_VER) & (w_sum == {WIDTH{1'b1}});
            r_m_err      <= w_err_next;
            r_m_count    <= w_count_next;
        end
    end

    assign s_ready    = r_s_ready;
    assign m_valid    = r_m_valid;
    assign m_checksum = r_m_checksum;
    assign m_ok       = r_m_ok;
    assign m_err      = r_m_err;
    assign m_count    = r_m_count;

endmodule

// File: tb/tb_stream_checksum.sv
// Self-checking bench for stream_checksum: directed vector table, corner
// sequences (abort, reset, backpressure) and randomized packets.
module tb_stream_checksum;

    localparam int         W    = 8;
    localparam int         MAXW = 4;
    localparam logic [7:0] SD   = 8'h00;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       abort;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_checksum;
    logic       m_ok;
    logic       m_err;
    logic [2:0] m_count;

    int n_tests;
    int n_fail;

    stream_checksum #(
        .WIDTH     (W),
        .MAX_WORDS (MAXW),
        .SEED      (SD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_checksum (m_checksum),
        .m_ok       (m_ok),
        .m_err      (m_err),
        .m_count    (m_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        md;
        int          n;
        logic [63:0] words;
        logic [7:0]  cs;
        logic        ok;
        int          cnt;
        logic        err;
        int          hold;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer sum of all words, then repeated end-around folding.
    function automatic void model(input logic md, input int n, input logic [63:0] words,
                                  output logic [7:0] cs, output logic ok,
                                  output int cnt, output logic err);
        int unsigned s;
        s = SD;
        for (int i = 0; i < n; i++) s += words[8*i +: 8];
        while (s > 255) s = (s % 256) + (s / 256);
        cs  = ~8'(s);
        ok  = md && (s == 255);
        cnt = (n > MAXW) ? MAXW : n;
        err = (n > MAXW);
    endfunction

    task automatic push_word(input logic [7:0] d, input logic last, input logic md);
        int guard;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        mode    = md;
        m_ready = 1'($urandom);
        guard   = 0;
        while (!s_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("s_ready_timeout", 64'(guard >= 20), 64'd0);
        @(posedge clk);
    endtask

    task automatic run_pkt(input string tag, input logic md, input int n, input logic [63:0] words,
                           input logic [7:0] e_cs, input logic e_ok, input int e_cnt,
                           input logic e_err, input int hold);
        logic [11:0] snap;
        for (int i = 0; i < n; i++) begin
            // mode is only honoured on the first word; later words carry noise
            push_word(words[8*i +: 8], (i == n - 1), (i == 0) ? md : 1'($urandom));
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = (hold == 0);
        chk({tag, ".m_valid"},    64'(m_valid),    64'd1);
        chk({tag, ".checksum"},   64'(m_checksum), 64'(e_cs));
        chk({tag, ".ok"},         64'(m_ok),       64'(e_ok));
        chk({tag, ".count"},      64'(m_count),    64'(e_cnt));
        chk({tag, ".err"},        64'(m_err),      64'(e_err));
        chk({tag, ".s_ready_lo"}, 64'(s_ready),    64'd0);
        snap = {m_checksum, m_ok, m_err, m_count[1:0]};
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"},  64'(m_valid), 64'd1);
            chk({tag, ".hold_sready"}, 64'(s_ready), 64'd0);
            chk({tag, ".hold_stable"}, 64'({m_checksum, m_ok, m_err, m_count[1:0]}), 64'(snap));
            if (k == hold - 1) m_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, ".taken_valid"},  64'(m_valid), 64'd0);
        chk({tag, ".taken_sready"}, 64'(s_ready), 64'd1);
        m_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  e_cs;
        logic        e_ok;
        logic        e_err;
        int          e_cnt;
        int          n;
        logic        md;
        logic [63:0] words;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        mode    = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b0;

        vt[0] = '{1'b0, 3, 64'h0000_0000_0056_3412, 8'h63, 1'b0, 3, 1'b0, 0};
        vt[1] = '{1'b0, 2, 64'h0000_0000_0000_01FF, 8'hFE, 1'b0, 2, 1'b0, 1};
        vt[2] = '{1'b0, 2, 64'h0000_0000_0000_FFFF, 8'h00, 1'b0, 2, 1'b0, 0};
        vt[3] = '{1'b1, 4, 64'h0000_0000_6356_3412, 8'h00, 1'b1, 4, 1'b0, 2};
        vt[4] = '{1'b1, 4, 64'h0000_0000_6256_3412, 8'h01, 1'b0, 4, 1'b0, 0};
        vt[5] = '{1'b0, 1, 64'h0000_0000_0000_00A5, 8'h5A, 1'b0, 1, 1'b0, 3};
        vt[6] = '{1'b0, 6, 64'h0000_0101_0101_0101, 8'hF9, 1'b0, 4, 1'b1, 0};
        vt[7] = '{1'b1, 1, 64'h0000_0000_0000_00FF, 8'h00, 1'b1, 1, 1'b0, 0};
        vt[8] = '{1'b0, 4, 64'h0000_0000_0000_0000, 8'hFF, 1'b0, 4, 1'b0, 0};
        vt[9] = '{1'b1, 5, 64'h0000_0001_0101_0101, 8'hFA, 1'b0, 4, 1'b1, 1};

        #12;
        chk("rst.m_valid", 64'(m_valid),    64'd0);
        chk("rst.cs",      64'(m_checksum), 64'd0);
        chk("rst.ok",      64'(m_ok),       64'd0);
        chk("rst.err",     64'(m_err),      64'd0);
        chk("rst.count",   64'(m_count),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.s_ready", 64'(s_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            run_pkt($sformatf("vec%0d", i), vt[i].md, vt[i].n, vt[i].words,
                    vt[i].cs, vt[i].ok, vt[i].cnt, vt[i].err, vt[i].hold);
        end

        // Abort mid-packet; the word presented with abort (marked last) must be dropped.
        push_word(8'h33, 1'b0, 1'b0);
        push_word(8'h44, 1'b0, 1'b0);
        @(negedge clk);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h77;
        s_last  = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("abort.m_valid", 64'(m_valid), 64'd0);
        chk("abort.s_ready", 64'(s_ready), 64'd1);
        run_pkt("abort_next", 1'b0, 1, 64'h10, 8'hEF, 1'b0, 1, 1'b0, 0);

        // Reset while accumulating.
        push_word(8'h55, 1'b0, 1'b0);
        push_word(8'h66, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_accum.m_valid", 64'(m_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_accum.s_ready", 64'(s_ready), 64'd1);
        run_pkt("rst_accum_next", 1'b0, 1, 64'h20, 8'hDF, 1'b0, 1, 1'b0, 0);

        // Reset while a result is pending.
        push_word(8'h5A, 1'b1, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        chk("rst_res.pre_valid", 64'(m_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_res.m_valid", 64'(m_valid),    64'd0);
        chk("rst_res.cs",      64'(m_checksum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_res.s_ready", 64'(s_ready), 64'd1);
        run_pkt("rst_res_next", 1'b1, 2, 64'hF00F, 8'h00, 1'b1, 2, 1'b0, 0);

        for (int r = 0; r < 40; r++) begin
            n     = $urandom_range(1, 6);
            md    = 1'($urandom);
            words = {$urandom, $urandom};
            if (r % 7 == 0) begin
                words[8*(n-1) +: 8] = 8'h00;
                model(md, n, words, e_cs, e_ok, e_cnt, e_err);
                words[8*(n-1) +: 8] = e_cs;
            end
            model(md, n, words, e_cs, e_ok, e_cnt, e_err);
            run_pkt($sformatf("rnd%0d", r), md, n, words, e_cs, e_ok, e_cnt, e_err,
                    $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
